// File: rtl/hazard_pkg.sv
// Shared state encoding for the pipeline hazard/flush controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_STALL    = 2'd1,
    HZ_REDIRECT = 2'd2
  } hz_state_e;

  localparam int HZ_CNT_W = 3;

endpackage

// File: rtl/hazard_flush_unit_sat_counter.sv
// Saturating event counter; holds at all-ones, clears only on reset.
module sat_counter #(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [NBits-1:0] count
);

  logic [NBits-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         count_q <= '0;
    else if (inc && (count_q != '1))  count_q <= count_q + 1'b1;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_flush_unit.sv
// Load-use stall and branch/jump redirect flush control for the 5-stage core.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_flush_unit
  import hazard_pkg::*;
#(
  parameter int NBits          = 32,
  parameter int RedirectCycles = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_Rs,
  input  logic [4:0]       id_Rt,
  input  logic             id_UsesRt,
  input  logic             ex_CtrlMemRead,
  input  logic [4:0]       ex_WriteRegister,
  input  logic             ex_BranchTaken,
  input  logic             ex_CtrlJump,
  output logic             out_PCWrite,
  output logic             out_IFIDWrite,
  output logic             out_IFIDFlush,
  output logic             out_IDEXFlush,
  output logic [1:0]       out_State,
  output logic [NBits-1:0] out_StallCount,
  output logic [NBits-1:0] out_FlushCount
);

  localparam logic [HZ_CNT_W-1:0] RC_M1 = HZ_CNT_W'(RedirectCycles - 1);

  hz_state_e           state_q;
  logic [HZ_CNT_W-1:0] cnt_q;
  logic                redirect, load_use, take_redirect, take_stall;

  always_comb begin
    redirect = ex_BranchTaken | ex_CtrlJump;
    load_use = ex_CtrlMemRead && (ex_WriteRegister != 5'd0) &&
               ((ex_WriteRegister == id_Rs) || (id_UsesRt && (ex_WriteRegister == id_Rt)));
    // EX holds a bubble in STALL, so only RUN can start a new stall.
    take_redirect = !reset && redirect && ((state_q == HZ_RUN) || (state_q == HZ_STALL));
    take_stall    = !reset && !redirect && load_use && (state_q == HZ_RUN);
  end

  always_comb begin
    out_PCWrite   = 1'b1;
    out_IFIDWrite = 1'b1;
    out_IFIDFlush = 1'b0;
    out_IDEXFlush = 1'b0;
    if (!reset) begin
      if (take_redirect || (state_q == HZ_REDIRECT)) begin
        out_IFIDFlush = 1'b1;
        out_IDEXFlush = 1'b1;
      end else if (take_stall) begin
        out_PCWrite   = 1'b0;
        out_IFIDWrite = 1'b0;
        out_IDEXFlush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        HZ_RUN, HZ_STALL: begin
          if (take_redirect) begin
            if (RedirectCycles > 1) begin
              state_q <= HZ_REDIRECT;
              cnt_q   <= RC_M1;
            end else begin
              state_q <= HZ_RUN;
            end
          end else if (take_stall) begin
            state_q <= HZ_STALL;
          end else begin
            state_q <= HZ_RUN;
          end
        end
        HZ_REDIRECT: begin
          if (cnt_q <= 1) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= HZ_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out_State = state_q;

`ifdef HAZARD_STATS_EN
  sat_counter #(.NBits(NBits)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (take_stall),
    .count (out_StallCount)
  );

  sat_counter #(.NBits(NBits)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (take_redirect),
    .count (out_FlushCount)
  );
`else
  assign out_StallCount = '0;
  assign out_FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_flush_unit.sv
// Scoreboard bench for hazard_flush_unit: directed test-plan cases then random traffic.
module tb_hazard_flush_unit;

  localparam int NB = 32;
  localparam int RC = 3;
  localparam int WATCHDOG_NS = 1000000;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_Rs, id_Rt, ex_WriteRegister;
  logic          id_UsesRt, ex_CtrlMemRead, ex_BranchTaken, ex_CtrlJump;
  logic          out_PCWrite, out_IFIDWrite, out_IFIDFlush, out_IDEXFlush;
  logic [1:0]    out_State;
  logic [NB-1:0] out_StallCount, out_FlushCount;

  hazard_flush_unit #(.NBits(NB), .RedirectCycles(RC)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_Rs            (id_Rs),
    .id_Rt            (id_Rt),
    .id_UsesRt        (id_UsesRt),
    .ex_CtrlMemRead   (ex_CtrlMemRead),
    .ex_WriteRegister (ex_WriteRegister),
    .ex_BranchTaken   (ex_BranchTaken),
    .ex_CtrlJump      (ex_CtrlJump),
    .out_PCWrite      (out_PCWrite),
    .out_IFIDWrite    (out_IFIDWrite),
    .out_IFIDFlush    (out_IFIDFlush),
    .out_IDEXFlush    (out_IDEXFlush),
    .out_State        (out_State),
    .out_StallCount   (out_StallCount),
    .out_FlushCount   (out_FlushCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    ctl;   // PCWrite, IFIDWrite, IFIDFlush, IDEXFlush
    logic [1:0]    st;
    logic [NB-1:0] sc;
    logic [NB-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   done   = 0;

  // Reference model: remaining flush cycles, whether EX holds a stall bubble, event tallies.
  int   m_flush_left = 0;
  bit   m_bubble     = 0;
  int   m_stalls     = 0;
  int   m_flushes    = 0;

  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic mr, input logic [4:0] wr,
                      input logic bt, input logic jp);
    exp_t e;
    bit   lu, rd;
    @(posedge clk);
    #1;
    reset = rst; id_Rs = rs; id_Rt = rt; id_UsesRt = ur;
    ex_CtrlMemRead = mr; ex_WriteRegister = wr; ex_BranchTaken = bt; ex_CtrlJump = jp;
    lu = mr && (wr != 0) && ((wr == rs) || (ur && (wr == rt)));
    rd = bt || jp;
    e.ctl = 4'b1100;
    if (rst) begin
      m_flush_left = 0; m_bubble = 0; m_stalls = 0; m_flushes = 0;
      e.st = 2'd0;
    end else begin
      e.st = (m_flush_left > 0) ? 2'd2 : (m_bubble ? 2'd1 : 2'd0);
    end
`ifdef HAZARD_STATS_EN
    e.sc = NB'(m_stalls);
    e.fc = NB'(m_flushes);
`else
    e.sc = '0;
    e.fc = '0;
`endif
    if (!rst) begin
      if (m_flush_left > 0) begin
        e.ctl = 4'b1111;
        m_flush_left--;
        m_bubble = 0;
      end else if (rd) begin
        e.ctl = 4'b1111;
        m_flush_left = RC - 1;
        m_flushes++;
        m_bubble = 0;
      end else if (lu && !m_bubble) begin
        e.ctl = 4'b0001;
        m_bubble = 1;
        m_stalls++;
      end else begin
        m_bubble = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({out_PCWrite, out_IFIDWrite, out_IFIDFlush, out_IDEXFlush} != mon_e.ctl ||
          out_State != mon_e.st || out_StallCount != mon_e.sc || out_FlushCount != mon_e.fc) begin
        errors++;
        $display("FAIL cyc%0d: ctl act=%b exp=%b state act=%0d exp=%0d stalls act=%0d exp=%0d flushes act=%0d exp=%0d",
                 cyc, {out_PCWrite, out_IFIDWrite, out_IFIDFlush, out_IDEXFlush}, mon_e.ctl,
                 out_State, mon_e.st, out_StallCount, mon_e.sc, out_FlushCount, mon_e.fc);
      end
    end
  end

  initial begin
    #(WATCHDOG_NS);
    if (!done) begin
      errors++;
      $display("FAIL: watchdog expired after %0d ns waiting for the test to finish", WATCHDOG_NS);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    reset = 1'b1; id_Rs = '0; id_Rt = '0; id_UsesRt = 1'b0;
    ex_CtrlMemRead = 1'b0; ex_WriteRegister = '0; ex_BranchTaken = 1'b0; ex_CtrlJump = 1'b0;

    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (out_State != 2'd0 || out_PCWrite != 1'b1 || out_IFIDWrite != 1'b1 ||
        out_IFIDFlush != 1'b0 || out_IDEXFlush != 1'b0 ||
        out_StallCount != '0 || out_FlushCount != '0) begin
      errors++;
      $display("FAIL reset state: state=%0d ctl=%b stalls=%0d flushes=%0d",
               out_State, {out_PCWrite, out_IFIDWrite, out_IFIDFlush, out_IDEXFlush},
               out_StallCount, out_FlushCount);
    end
    step(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    idle();
    // load-use on rs, held for two cycles: second cycle is the bubble
    step(1'b0, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    step(1'b0, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    idle();
    // rt matches but is not used
    step(1'b0, 5'd9, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    // rt matches and is used
    step(1'b0, 5'd9, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    idle();
    // destination $zero
    step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    // taken branch, three flush cycles; redirect during REDIRECT ignored
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle();
    idle();
    // jump with simultaneous load-use
    step(1'b0, 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
    idle();
    idle();
    // redirect during STALL
    step(1'b0, 5'd4, 5'd2, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
    step(1'b0, 5'd4, 5'd2, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
    idle();
    idle();
    // reset in the second REDIRECT cycle
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle();
    step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    idle();

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL: %0d expected samples never checked", exp_q.size());
    end
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_flush_unit.md
# hazard_flush_unit

Pipeline hazard and flush controller for the 5-stage core. It sits beside the IF/ID and ID/EX pipeline registers and drives their write-enable and Flush inputs, plus the PC write enable. It detects load-use hazards between the instruction in ID and a load in EX, and inserts a one-cycle bubble. On a taken branch or jump resolved in EX, it squashes the wrong-path instructions for a programmable number of cycles.

## Interface
- NBits, 32, width of the statistics counters
- RedirectCycles, 1, flush cycles per taken branch/jump (legal range 1..7)

Ports:
- clk  in  1  clock; state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- id_Rs  in  5  rs field of the instruction in ID
- id_Rt  in  5  rt field of the instruction in ID
- id_UsesRt  in  1  instruction in ID reads rt as a source
- ex_CtrlMemRead  in  1  ID/EX MemRead control
- ex_WriteRegister  in  5  ID/EX destination register
- ex_BranchTaken  in  1  branch in EX resolved taken (BEQ/BNE outcome)
- ex_CtrlJump  in  1  ID/EX Jump control
- out_PCWrite  out  1  PC load enable
- out_IFIDWrite  out  1  IF/ID load enable
- out_IFIDFlush  out  1  IF/ID flush
- out_IDEXFlush  out  1  ID/EX flush (bubble insert)
- out_State  out  2  current FSM state
- out_StallCount  out  NBits  load-use stalls taken
- out_FlushCount  out  NBits  redirect events taken

## Operation
- Redirect = ex_BranchTaken | ex_CtrlJump.
- LoadUse = ex_CtrlMemRead & (ex_WriteRegister != 0) & ((ex_WriteRegister == id_Rs) | (id_UsesRt & ex_WriteRegister == id_Rt)).
- Outputs are combinational from the current state and inputs. Default outputs: PCWrite=1, IFIDWrite=1, both flushes 0.

States:
- RUN:
  - On Redirect: IFIDFlush=1, IDEXFlush=1, PCWrite=1. If RedirectCycles>1, go to REDIRECT with cnt=RedirectCycles-1; otherwise stay in RUN.
  - Else on LoadUse: PCWrite=0, IFIDWrite=0, IDEXFlush=1, then go to STALL.
  - Else: default outputs, stay in RUN.
- STALL:
  - Lasts exactly one cycle.
  - LoadUse detection is disabled because a bubble occupies EX.
  - Redirect is still honoured with the same outputs and transitions as in RUN.
  - Otherwise: default outputs, go to RUN.
- REDIRECT:
  - IFIDFlush=1, IDEXFlush=1, PCWrite=1.
  - cnt decrements each cycle; go to RUN when cnt reaches 1.
  - A new Redirect during REDIRECT is ignored, because EX holds a flushed bubble.
- Priority: Redirect over LoadUse in the same cycle, because the load-dependent instruction is on the wrong path.
- State encoding: RUN=0, STALL=1, REDIRECT=2. Encoding 3 is illegal and recovers to RUN on the next edge.

## Timing
- Hazard response has zero-cycle latency: outputs are valid in the same cycle the inputs are presented.
- A stall costs exactly 1 cycle.
- A redirect costs RedirectCycles cycles of flush.
- Reset values:
  - State=RUN, cnt=0, both statistics counters 0.
  - While reset is high, outputs are forced to PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXFlush=0.
- Reset asserted mid-REDIRECT or mid-STALL abandons the remaining cycles; the unit resumes in RUN after reset deasserts.
- ex_WriteRegister=0 never causes a stall.

## Configuration
- HAZARD_STATS_EN defined:
  - out_StallCount increments on each RUN→STALL transition.
  - out_FlushCount increments once per accepted Redirect, not per flush cycle.
  - Both counters saturate at all-ones and clear only on reset.
- HAZARD_STATS_EN undefined: both ports are tied to 0 and no counter flops are synthesised.

## Structure
- Shared package hazard_pkg holds the state localparams (HZ_RUN, HZ_STALL, HZ_REDIRECT) and the 2-bit state typedef.
- One sub-module, sat_counter (parameter NBits; inputs clk, reset, inc; output count), is instantiated twice under HAZARD_STATS_EN.

## Test plan
- Load-use hazard on rs: ex_CtrlMemRead=1, ex_WriteRegister=8, id_Rs=8 → PCWrite=0, IFIDWrite=0, IDEXFlush=1 for 1 cycle; State 0→1→0; StallCount=1.
- rt not used: id_Rt=8, id_UsesRt=0, id_Rs=9, other conditions as above → no stall, outputs at defaults.
- Destination is $zero: ex_WriteRegister=0, id_Rs=0, ex_CtrlMemRead=1 → no stall.
- Redirect with RedirectCycles=3: pulse ex_BranchTaken → IFIDFlush=IDEXFlush=1 for 3 consecutive cycles; State 0→2→2→0; FlushCount=1.
- Redirect and load-use together: ex_CtrlJump=1 with LoadUse true in the same cycle → flushes asserted, PCWrite=1, no stall; StallCount unchanged.
- Reset mid-redirect: assert reset in the 2nd REDIRECT cycle → State=0, flushes drop immediately, counters read 0 after release.
